// File: rtl/wb_arb_pkg.sv
// Shared constants and types for the register-file write-back arbiter.
package wb_arb_pkg;

  localparam int WB_NUM_REQ = 3;
  localparam int WB_DATA_W  = 32;
  localparam int WB_ADDR_W  = 5;
  localparam int REG_COUNT  = 2 ** WB_ADDR_W;

  typedef logic [WB_ADDR_W-1:0]          reg_addr_t;
  typedef logic [$clog2(WB_NUM_REQ)-1:0] src_idx_t;

endpackage

// File: rtl/wb_addr_decoder.sv
// Register-address to one-hot enable decode, gated by a valid input.
// Register 0 is hard-wired and never receives an enable.
module wb_addr_decoder
  import wb_arb_pkg::*;
#(
  parameter int ADDR_W = WB_ADDR_W
) (
  input  logic [ADDR_W-1:0]       addr_i,
  input  logic                    valid_i,
  output logic [(1<<ADDR_W)-1:0]  onehot_o
);

  // One-hot decode with bit 0 forced low.
  always_comb begin
    onehot_o = '0;
    if (valid_i && (addr_i != '0)) begin
      onehot_o[addr_i] = 1'b1;
    end
  end

endmodule

// File: rtl/wb_port_arbiter.sv
// Write-back port arbiter: grants one requester per cycle onto the single
// register-file write port and registers its address/data/enable.
// Build option: define WB_ARB_FIXED_PRIO_EN for fixed lowest-index-wins
// priority (no rotating pointer); default is round-robin.
module wb_port_arbiter
  import wb_arb_pkg::*;
#(
  parameter int NUM_REQ = WB_NUM_REQ,
  parameter int DATA_W  = WB_DATA_W,
  parameter int ADDR_W  = WB_ADDR_W,
  localparam int SRC_W  = $clog2(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      clr,
  input  logic                      freeze,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [(1<<ADDR_W)-1:0]    wr_en_vec,
  output logic [ADDR_W-1:0]         wr_addr,
  output logic [DATA_W-1:0]         wr_data,
  output logic [SRC_W-1:0]          wr_src
);

  logic [NUM_REQ-1:0]     grant_oh;
  logic [SRC_W-1:0]       grant_idx;
  logic                   xfer;
  logic [ADDR_W-1:0]      sel_addr;
  logic [DATA_W-1:0]      sel_data;
  logic [(1<<ADDR_W)-1:0] dec_vec;

  logic [(1<<ADDR_W)-1:0] wr_en_vec_q;
  logic [ADDR_W-1:0]      wr_addr_q;
  logic [DATA_W-1:0]      wr_data_q;
  logic [SRC_W-1:0]       wr_src_q;

`ifdef WB_ARB_FIXED_PRIO_EN
  // Fixed priority: scan high to low so the lowest valid index is kept.
  always_comb begin
    grant_oh  = '0;
    grant_idx = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req_valid[i]) begin
        grant_oh    = '0;
        grant_oh[i] = 1'b1;
        grant_idx   = SRC_W'(i);
      end
    end
  end
`else
  logic [SRC_W-1:0] prio_q, prio_d;

  // Round-robin: scan prio+k in reverse so the first valid from prio wins.
  always_comb begin
    int idx;
    idx       = 0;
    grant_oh  = '0;
    grant_idx = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = int'(prio_q) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (req_valid[idx]) begin
        grant_oh      = '0;
        grant_oh[idx] = 1'b1;
        grant_idx     = SRC_W'(idx);
      end
    end
  end

  // Pointer moves past the winner only when a transfer actually happens.
  always_comb begin
    prio_d = prio_q;
    if (xfer) begin
      prio_d = (grant_idx == SRC_W'(NUM_REQ - 1)) ? '0 : grant_idx + SRC_W'(1);
    end
  end

  // Round-robin pointer register.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) prio_q <= '0;
    else     prio_q <= prio_d;
  end
`endif

  // Grant is suppressed during stall and while reset is held.
  always_comb begin
    req_ready = grant_oh & {NUM_REQ{~(freeze | clr)}};
    xfer      = |req_ready;
  end

  // Winner's address and data, selected by the one-hot grant.
  always_comb begin
    sel_addr = '0;
    sel_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (req_ready[i]) begin
        sel_addr = req_addr[i*ADDR_W +: ADDR_W];
        sel_data = req_data[i*DATA_W +: DATA_W];
      end
    end
  end

  // Decode before the register so the bank enables come straight from flops.
  wb_addr_decoder #(
    .ADDR_W (ADDR_W)
  ) u_dec (
    .addr_i   (sel_addr),
    .valid_i  (xfer),
    .onehot_o (dec_vec)
  );

  // Output slot: enable reloads every edge, payload holds without a transfer.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      wr_en_vec_q <= '0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      wr_src_q    <= '0;
    end else begin
      wr_en_vec_q <= dec_vec;
      if (xfer) begin
        wr_addr_q <= sel_addr;
        wr_data_q <= sel_data;
        wr_src_q  <= grant_idx;
      end
    end
  end

  assign wr_en_vec = wr_en_vec_q;
  assign wr_addr   = wr_addr_q;
  assign wr_data   = wr_data_q;
  assign wr_src    = wr_src_q;

endmodule
